// File: rtl/sync_event_collector.sv
// sync_event_collector
// Turns an already-synchronized level into counted events. Each rising edge of
// sync_i adds one pending event. The consumer drains the whole batch with a
// valid/ready handshake. The count saturates at its maximum, and a sticky
// overflow flag records any event lost to saturation. clr_i clears both the
// count and the flag.
//
// Priority per cycle: clr_i, then handshake, then edge.

module sync_event_collector #(
   parameter int unsigned CNT_W = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             sync_i,
   input  logic             clr_i,
   output logic             edge_o,
   output logic             evt_valid_o,
   input  logic             evt_ready_i,
   output logic [CNT_W-1:0] evt_cnt_o,
   output logic             ovf_o
);

   // The FSM encoding is private to this block; no other block relies on it.
   typedef enum logic {
      IDLE = 1'b0,   // no pending events, cnt == 0
      PEND = 1'b1    // one or more pending events, cnt != 0
   } state_t;

   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   state_t           state;
   state_t           state_nxt;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_nxt;
   logic             ovf;
   logic             ovf_nxt;
   logic             sync_d;
   logic             rise;
   logic             handshake;

   // Previous-cycle sample of sync_i, used for rising-edge detection.
   // sync_d resets to 0, so a sync_i that is already high when reset is
   // released counts as an edge in the first cycle after release.
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: sequential state uses non-blocking (<=) so that every flop
      // samples pre-edge values and the simulation order of processes does
      // not matter.
      if (!rst_n) begin
         sync_d <= 1'b0;
      end else begin
         sync_d <= sync_i;
      end
   end

   assign rise      = sync_i & ~sync_d;
   assign handshake = (state == PEND) & evt_ready_i;

   // Next-state, count and overflow decisions in priority order: clear,
   // then handshake, then edge.
   always_comb begin
      // NOTE: each variable gets a default before any branch. Otherwise a path
      // that does not assign it would imply memory and infer a latch.
      state_nxt = state;
      cnt_nxt   = cnt;
      ovf_nxt   = ovf;

      if (clr_i) begin
         // An edge in the same cycle is dropped. edge_o still pulses.
         state_nxt = IDLE;
         cnt_nxt   = '0;
         ovf_nxt   = 1'b0;
      end else if (handshake) begin
         // The consumer takes the current count. A coincident edge
         // starts the next batch at 1.
         if (rise) begin
            state_nxt = PEND;
            cnt_nxt   = CNT_ONE;
         end else begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
         end
      end else if (rise) begin
         state_nxt = PEND;
         if (cnt != CNT_MAX) begin
            cnt_nxt = cnt + CNT_ONE;
         end else begin
            // At saturation the count holds and the lost event is recorded.
            ovf_nxt = 1'b1;
         end
      end
   end

   // FSM state, pending count and sticky overflow registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         cnt   <= '0;
         ovf   <= 1'b0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         ovf   <= ovf_nxt;
      end
   end

   assign edge_o      = rise;
   assign evt_valid_o = (state == PEND);
   assign evt_cnt_o   = cnt;
   assign ovf_o       = ovf;

endmodule

// File: tb/tb_sync_event_collector.sv
// Testbench for sync_event_collector (CNT_W = 4).
// Each directed step drives the inputs for one cycle and pushes the outputs
// expected in that cycle onto a scoreboard queue. The entry is popped and
// compared at the falling edge, away from the active clock edge.

module tb_sync_event_collector;

   localparam int unsigned CNT_W = 4;

   typedef struct {
      logic             edge_v;
      logic             valid;
      logic [CNT_W-1:0] cnt;
      logic             ovf;
      string            tag;
   } exp_t;

   logic             clk;
   logic             rst_n;
   logic             sync_i;
   logic             clr_i;
   logic             edge_o;
   logic             evt_valid_o;
   logic             evt_ready_i;
   logic [CNT_W-1:0] evt_cnt_o;
   logic             ovf_o;

   exp_t exp_q[$];
   int   compared   = 0;
   int   mismatched = 0;

   sync_event_collector #(
      .CNT_W (CNT_W)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .sync_i      (sync_i),
      .clr_i       (clr_i),
      .edge_o      (edge_o),
      .evt_valid_o (evt_valid_o),
      .evt_ready_i (evt_ready_i),
      .evt_cnt_o   (evt_cnt_o),
      .ovf_o       (ovf_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Pushes the outputs expected in the current cycle onto the scoreboard.
   task automatic expect_out(input logic e_edge, input logic e_valid,
                             input logic [CNT_W-1:0] e_cnt, input logic e_ovf,
                             input string tag);
      exp_t e;
      e.edge_v = e_edge;
      e.valid  = e_valid;
      e.cnt    = e_cnt;
      e.ovf    = e_ovf;
      e.tag    = tag;
      exp_q.push_back(e);
   endtask

   // Pops the oldest expected entry and compares it with the live DUT outputs.
   task automatic check();
      exp_t e;
      if (exp_q.size() == 0) begin
         compared++;
         mismatched++;
         $error("FAIL scoreboard_empty: observed no entry, expected one");
         return;
      end
      e = exp_q.pop_front();
      compared++;
      assert (edge_o === e.edge_v) else begin
         mismatched++;
         $error("FAIL %s edge_o: observed %b expected %b", e.tag, edge_o, e.edge_v);
      end
      compared++;
      assert (evt_valid_o === e.valid) else begin
         mismatched++;
         $error("FAIL %s evt_valid_o: observed %b expected %b", e.tag, evt_valid_o, e.valid);
      end
      compared++;
      assert (evt_cnt_o === e.cnt) else begin
         mismatched++;
         $error("FAIL %s evt_cnt_o: observed %0d expected %0d", e.tag, evt_cnt_o, e.cnt);
      end
      compared++;
      assert (ovf_o === e.ovf) else begin
         mismatched++;
         $error("FAIL %s ovf_o: observed %b expected %b", e.tag, ovf_o, e.ovf);
      end
   endtask

   // One clock cycle. Entered 1 time unit after a rising edge. Drives the inputs,
   // checks the outputs at the falling edge, and returns 1 unit after the next
   // rising edge.
   task automatic step(input logic s, input logic c, input logic r,
                       input logic e_edge, input logic e_valid,
                       input logic [CNT_W-1:0] e_cnt, input logic e_ovf,
                       input string tag);
      sync_i      = s;
      clr_i       = c;
      evt_ready_i = r;
      expect_out(e_edge, e_valid, e_cnt, e_ovf, tag);
      @(negedge clk);
      check();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n       = 1'b0;
      sync_i      = 1'b0;
      clr_i       = 1'b0;
      evt_ready_i = 1'b0;

      // Reset state.
      #2;
      expect_out(1'b0, 1'b0, 4'd0, 1'b0, "reset_state");
      check();
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Level held high for 5 cycles from cycle 3 counts as one event.
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, "lvl_c0");
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, "lvl_c1");
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, "lvl_c2");
      step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0, "lvl_c3_edge");
      for (int i = 4; i < 8; i++)
         step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'd1, 1'b0, $sformatf("lvl_c%0d_hold", i));
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd1, 1'b0, "lvl_c8_low");
      step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'd1, 1'b0, "lvl_handshake");
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, "lvl_drained");

      // Three one-cycle pulses spaced two cycles apart, then a ready pulse.
      step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0, "pul1_edge");
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd1, 1'b0, "pul1_cnt1");
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd1, 1'b0, "pul1_gap");
      step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 4'd1, 1'b0, "pul2_edge");
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd2, 1'b0, "pul2_cnt2");
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd2, 1'b0, "pul2_gap");
      step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 4'd2, 1'b0, "pul3_edge");
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd3, 1'b0, "pul3_cnt3");
      step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'd3, 1'b0, "pul_handshake");
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, "pul_drained");

      // Ready while idle has no effect.
      step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, "idle_ready");
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, "idle_ready_after");

      // Handshake coincident with an edge restarts the batch at 1.
      step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0, "hse_edge1");
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd1, 1'b0, "hse_cnt1");
      step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 4'd1, 1'b0, "hse_edge2");
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd2, 1'b0, "hse_cnt2");
      step(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 4'd2, 1'b0, "hse_hs_and_edge");
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd1, 1'b0, "hse_restart_1");
      step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'd1, 1'b0, "hse_handshake");
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, "hse_drained");

      // 17 edges with ready low: saturation at 15, overflow after the 16th.
      for (int i = 1; i <= 17; i++) begin
         step(1'b1, 1'b0, 1'b0, 1'b1, (i > 1),
              (i - 1 > 15) ? 4'd15 : 4'((i - 1)), (i - 1 >= 16),
              $sformatf("sat_edge%0d", i));
         step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1,
              (i > 15) ? 4'd15 : 4'(i), (i >= 16),
              $sformatf("sat_after%0d", i));
      end
      step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'd15, 1'b1, "sat_handshake");
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0,  1'b1, "sat_ovf_sticky");
      step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0,  1'b1, "sat_new_edge");
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd1,  1'b1, "sat_new_cnt1");
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'd1,  1'b1, "sat_clr");
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0,  1'b0, "sat_cleared");

      // Clear coincident with an edge and a handshake wins.
      step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0, "clr_pre_edge");
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd1, 1'b0, "clr_pre_cnt1");
      step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 4'd1, 1'b0, "clr_edge_hs");
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, "clr_result");

      // Build a count of 7, then assert reset asynchronously.
      for (int i = 1; i <= 7; i++) begin
         step(1'b1, 1'b0, 1'b0, 1'b1, (i > 1), 4'((i - 1)), 1'b0,
              $sformatf("rst_edge%0d", i));
         step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'(i), 1'b0,
              $sformatf("rst_cnt%0d", i));
      end
      rst_n = 1'b0;
      #1;
      expect_out(1'b0, 1'b0, 4'd0, 1'b0, "async_reset");
      check();
      sync_i = 1'b1;
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      expect_out(1'b1, 1'b0, 4'd0, 1'b0, "release_high_edge");
      check();
      @(posedge clk);
      #1;
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'd1, 1'b0, "release_one_event");
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'd1, 1'b0, "release_held");
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd1, 1'b0, "release_low");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
